// File: rtl/vai_c1_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : vai_c1_tx_arbiter_if
// Brief    : Per-sub-AFU c1 write request ports and merged c1 Tx output.
// Revision : 1.0
// ============================================================================
interface vai_c1_tx_arbiter_if #(
    parameter int NUM_SUB_AFUS = 8,
    parameter int HDR_W        = 80,
    parameter int DATA_W       = 512
);
    localparam int VMID_W = $clog2(NUM_SUB_AFUS);

    logic [NUM_SUB_AFUS-1:0]             in_valid;
    logic [NUM_SUB_AFUS-1:0]             in_last;
    logic [NUM_SUB_AFUS-1:0][HDR_W-1:0]  in_hdr;
    logic [NUM_SUB_AFUS-1:0][DATA_W-1:0] in_data;
    logic [NUM_SUB_AFUS-1:0]             in_ready;

    logic                                out_valid;
    logic [HDR_W-1:0]                    out_hdr;
    logic [DATA_W-1:0]                   out_data;
    logic [VMID_W-1:0]                   out_vmid;
    logic                                out_last;

    modport master (
        output in_valid, in_last, in_hdr, in_data,
        input  in_ready, out_valid, out_hdr, out_data, out_vmid, out_last
    );

    modport slave (
        input  in_valid, in_last, in_hdr, in_data,
        output in_ready, out_valid, out_hdr, out_data, out_vmid, out_last
    );
endinterface
`default_nettype wire

// File: rtl/vai_c1_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : vai_c1_tx_arbiter
// Brief    : Round-robin, burst-atomic arbiter sharing CCI-P Tx c1 among sub-AFUs.
// Revision : 1.0
// ============================================================================
module vai_c1_tx_arbiter #(
    parameter int NUM_SUB_AFUS = 8,
    parameter int HDR_W        = 80,
    parameter int DATA_W       = 512
) (
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        i_almost_full,
    input  wire logic [63:0] i_sub_afu_reset,
    vai_c1_tx_arbiter_if.slave bus
);
    localparam int VW = $clog2(NUM_SUB_AFUS);

    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [VW-1:0]           r_rr_ptr;
    logic [VW-1:0]           w_rr_nxt;
    logic [VW-1:0]           r_lock_port;
    logic [VW-1:0]           w_lock_nxt;
    logic [NUM_SUB_AFUS-1:0] w_elig;
    logic [NUM_SUB_AFUS-1:0] w_ready;
    logic [VW-1:0]           w_grant;
    logic [VW-1:0]           w_idx;
    logic [VW-1:0]           w_sel;
    logic                    w_found;
    logic                    w_accept;
    logic                    w_last;
    logic                    w_unused_rst;

    logic                    r_out_valid;
    logic                    r_out_last;
    logic [VW-1:0]           r_out_vmid;
    logic [HDR_W-1:0]        r_out_hdr;
    logic [DATA_W-1:0]       r_out_data;

    assign w_elig       = bus.in_valid & ~i_sub_afu_reset[NUM_SUB_AFUS-1:0];
    assign w_unused_rst = ^i_sub_afu_reset;

    // Scan starts one past the last served port; k==NUM_SUB_AFUS wraps back to it.
    always_comb begin : p_scan
        w_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        for (int k = 1; k <= NUM_SUB_AFUS; k++) begin
            w_idx = r_rr_ptr + VW'(k);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_grant = w_idx;
            end
        end
    end

    always_comb begin : p_fsm
        w_state_nxt = r_state;
        w_rr_nxt    = r_rr_ptr;
        w_lock_nxt  = r_lock_port;
        w_ready     = '0;
        w_sel       = (r_state == ST_IDLE) ? w_grant : r_lock_port;
        if (!reset && !i_almost_full) begin
            // An open burst owns the channel even if its sub-AFU enters reset.
            if (r_state == ST_LOCKED)
                w_ready[r_lock_port] = 1'b1;
            else if (w_found)
                w_ready[w_grant] = 1'b1;
        end
        w_accept = |(w_ready & bus.in_valid);
        w_last   = bus.in_last[w_sel];
        if (w_accept) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_last) begin
                        w_rr_nxt = w_grant;
                    end else begin
                        w_state_nxt = ST_LOCKED;
                        w_lock_nxt  = w_grant;
                    end
                end
                ST_LOCKED: begin
                    if (w_last) begin
                        w_state_nxt = ST_IDLE;
                        w_rr_nxt    = r_lock_port;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin : p_state
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin : p_regs
        if (reset) begin
            r_rr_ptr    <= VW'(NUM_SUB_AFUS - 1);
            r_lock_port <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_vmid  <= '0;
            r_out_hdr   <= '0;
            r_out_data  <= '0;
        end else begin
            r_rr_ptr    <= w_rr_nxt;
            r_lock_port <= w_lock_nxt;
            r_out_valid <= w_accept;
            r_out_last  <= w_accept & w_last;
            r_out_vmid  <= w_accept ? w_sel : '0;
            if (w_accept) begin
                r_out_hdr  <= bus.in_hdr[w_sel];
                r_out_data <= bus.in_data[w_sel];
            end
        end
    end

    assign bus.in_ready  = w_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.out_vmid  = r_out_vmid;
    assign bus.out_hdr   = r_out_hdr;
    assign bus.out_data  = r_out_data;
endmodule
`default_nettype wire

// File: tb/tb_vai_c1_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_vai_c1_tx_arbiter
// Brief    : Directed self-checking bench for the c1 Tx round-robin arbiter.
// Revision : 1.0
// ============================================================================
module tb_vai_c1_tx_arbiter;
    localparam int N  = 8;
    localparam int HW = 80;
    localparam int DW = 512;

    logic        clk = 1'b0;
    logic        reset;
    logic        almost_full;
    logic [63:0] sub_afu_reset;
    int          n_pass  = 0;
    int          n_total = 0;

    vai_c1_tx_arbiter_if #(.NUM_SUB_AFUS(N), .HDR_W(HW), .DATA_W(DW)) bus ();

    vai_c1_tx_arbiter #(.NUM_SUB_AFUS(N), .HDR_W(HW), .DATA_W(DW)) dut (
        .clk             (clk),
        .reset           (reset),
        .i_almost_full   (almost_full),
        .i_sub_afu_reset (sub_afu_reset),
        .bus             (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic chk_rdy(input string tag, input logic [N-1:0] exp);
        #1;
        chk(tag, 512'(bus.in_ready), 512'(exp));
    endtask

    // Packs {valid, vmid, last} so each output beat is one comparison.
    task automatic chk_out(input string tag, input logic v, input logic [2:0] vm, input logic l);
        chk(tag, 512'({bus.out_valid, bus.out_vmid, bus.out_last}), 512'({v, vm, l}));
    endtask

    initial begin
        logic [2:0] exp_order [6];
        exp_order = '{3'd5, 3'd0, 3'd2, 3'd5, 3'd0, 3'd2};

        reset         = 1'b1;
        almost_full   = 1'b0;
        sub_afu_reset = '0;
        bus.in_valid  = '1;
        bus.in_last   = '1;
        for (int p = 0; p < N; p++) begin
            bus.in_hdr[p]  = HW'(p * 16);
            bus.in_data[p] = {16{32'(p)}};
        end
        tick();
        tick();
        chk_rdy("rst_ready", 8'h00);
        chk_out("rst_out", 1'b0, 3'd0, 1'b0);
        chk("rst_hdr", 512'(bus.out_hdr), 512'd0);
        chk("rst_data", bus.out_data, 512'd0);
        bus.in_valid = '0;
        reset        = 1'b0;

        // Lone port 3, single-beat writes on three consecutive cycles.
        bus.in_valid = 8'h08;
        for (int i = 0; i < 3; i++) begin
            chk_rdy("p3_ready", 8'h08);
            tick();
            chk_out("p3_out", 1'b1, 3'd3, 1'b1);
        end
        bus.in_valid = '0;
        chk_rdy("p3_idle_ready", 8'h00);
        tick();
        chk_out("p3_idle_out", 1'b0, 3'd0, 1'b0);

        // Ports 0,2,5 contending; pointer sits at 3 so 5 leads.
        bus.in_valid = 8'b0010_0101;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk_out("rr_order", 1'b1, exp_order[i], 1'b1);
        end
        bus.in_valid = '0;
        tick();
        chk_out("rr_idle", 1'b0, 3'd0, 1'b0);

        // Move pointer to 0, then port 1 four-beat burst with ports 0 and 2 waiting.
        bus.in_valid = 8'h01;
        tick();
        chk_out("prep_p0", 1'b1, 3'd0, 1'b1);
        bus.in_valid = 8'b0000_0111;
        bus.in_last  = 8'b1111_1101;
        for (int b = 0; b < 3; b++) begin
            chk_rdy("burst_ready", 8'h02);
            tick();
            chk_out("burst_beat", 1'b1, 3'd1, 1'b0);
        end
        bus.in_last   = '1;
        bus.in_hdr[1] = 80'hB4;
        chk_rdy("burst_last_ready", 8'h02);
        tick();
        chk_out("burst_last", 1'b1, 3'd1, 1'b1);
        chk("burst_hdr", 512'(bus.out_hdr), 512'h B4);
        chk("burst_data", bus.out_data, {16{32'd1}});
        bus.in_valid = 8'b0000_0101;
        chk_rdy("after_burst_p2", 8'h04);
        tick();
        chk_out("after_burst_p2_out", 1'b1, 3'd2, 1'b1);
        chk_rdy("after_burst_p0", 8'h01);
        tick();
        chk_out("after_burst_p0_out", 1'b1, 3'd0, 1'b1);
        bus.in_valid = '0;
        tick();

        // Port 4 burst stalled by almost_full for 3 cycles after beat 1.
        bus.in_valid = 8'h10;
        bus.in_last  = 8'h00;
        chk_rdy("af_b1_ready", 8'h10);
        tick();
        chk_out("af_b1", 1'b1, 3'd4, 1'b0);
        almost_full  = 1'b1;
        bus.in_valid = 8'h11;
        for (int i = 0; i < 3; i++) begin
            chk_rdy("af_ready", 8'h00);
            tick();
            chk_out("af_out", 1'b0, 3'd0, 1'b0);
        end
        almost_full = 1'b0;
        chk_rdy("af_resume_ready", 8'h10);
        tick();
        chk_out("af_b2", 1'b1, 3'd4, 1'b0);
        tick();
        chk_out("af_b3", 1'b1, 3'd4, 1'b0);
        bus.in_last = '1;
        tick();
        chk_out("af_b4", 1'b1, 3'd4, 1'b1);
        bus.in_valid = '0;
        tick();
        chk_out("af_done", 1'b0, 3'd0, 1'b0);

        // Port 2 held in sub-AFU reset while port 3 competes.
        sub_afu_reset = 64'h4;
        bus.in_valid  = 8'h0C;
        chk_rdy("mask_ready1", 8'h08);
        tick();
        chk_out("mask_out1", 1'b1, 3'd3, 1'b1);
        chk_rdy("mask_ready2", 8'h08);
        tick();
        chk_out("mask_out2", 1'b1, 3'd3, 1'b1);
        sub_afu_reset = '0;
        chk_rdy("unmask_ready", 8'h04);
        tick();
        chk_out("unmask_out", 1'b1, 3'd2, 1'b1);
        bus.in_valid = 8'h04;
        bus.in_last  = 8'h00;
        tick();
        chk_out("p2_burst_b1", 1'b1, 3'd2, 1'b0);
        sub_afu_reset = 64'h4;
        chk_rdy("p2_locked_ready", 8'h04);
        tick();
        chk_out("p2_burst_b2", 1'b1, 3'd2, 1'b0);
        bus.in_last = '1;
        tick();
        chk_out("p2_burst_last", 1'b1, 3'd2, 1'b1);
        chk_rdy("p2_masked_idle", 8'h00);
        bus.in_valid  = '0;
        sub_afu_reset = '0;
        tick();

        // Pointer wrap from 7 to 0, then reset in the middle of a port 0 burst.
        bus.in_valid = 8'h80;
        chk_rdy("wrap_prep_ready", 8'h80);
        tick();
        chk_out("wrap_prep_out", 1'b1, 3'd7, 1'b1);
        bus.in_valid = 8'h81;
        bus.in_last  = 8'hFE;
        chk_rdy("wrap_ready", 8'h01);
        tick();
        chk_out("wrap_out", 1'b1, 3'd0, 1'b0);
        reset = 1'b1;
        chk_rdy("midrst_ready", 8'h00);
        tick();
        chk_out("midrst_out", 1'b0, 3'd0, 1'b0);
        reset        = 1'b0;
        bus.in_valid = 8'h80;
        chk_rdy("postrst_idle", 8'h80);
        bus.in_valid = 8'h81;
        bus.in_last  = '1;
        chk_rdy("postrst_p0", 8'h01);
        tick();
        chk_out("postrst_out", 1'b1, 3'd0, 1'b1);
        bus.in_valid = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/vai_c1_tx_arbiter.md
# vai_c1_tx_arbiter

Round-robin arbiter that shares the single CCI-P c1 (memory write) Tx channel among NUM_SUB_AFUS sub-AFUs in the virtualized-AFU mux. It sits between the per-sub-AFU write request ports and the CCI-P Tx c1 output. It keeps multi-line write bursts atomic, honours c1TxAlmFull backpressure, and masks sub-AFUs held in reset by the manager's sub_afu_reset register. Each forwarded beat is tagged with its source VMID for downstream address offsetting.

## Interface
- NUM_SUB_AFUS, 8, number of requesters (power of two, 2..64)
- HDR_W, 80, width of a c1 request header
- DATA_W, 512, width of a c1 data beat
- clk  in  1  CCI-P clock
- reset  in  1  synchronous, active-high
- almost_full  in  1  c1TxAlmFull from CCI-P; no beat accepted while high
- sub_afu_reset  in  64  bit i high = sub-AFU i in reset; bits >= NUM_SUB_AFUS ignored
- in_valid  in  NUM_SUB_AFUS  per-port beat valid
- in_last  in  NUM_SUB_AFUS  per-port beat is final beat of its burst (single-line write: last=1)
- in_hdr  in  NUM_SUB_AFUS x HDR_W  per-port header (meaningful on first beat, passed on every beat)
- in_data  in  NUM_SUB_AFUS x DATA_W  per-port data
- in_ready  out  NUM_SUB_AFUS  per-port accept; one-hot or zero; combinational
- out_valid  out  1  registered c1 valid
- out_hdr  out  HDR_W  registered header
- out_data  out  DATA_W  registered data
- out_vmid  out  $clog2(NUM_SUB_AFUS)  source port of out beat
- out_last  out  1  registered last flag

## Operation
- Accept on port i in a cycle = in_valid[i] & in_ready[i]; at most one accept per cycle.
- Eligible port i: in_valid[i] & ~sub_afu_reset[i].
- States: IDLE (no burst open), LOCKED(p) (burst from port p open).
- IDLE, almost_full=0: grant = first eligible port scanning rr_ptr+1, rr_ptr+2, ... wrapping modulo NUM_SUB_AFUS; in_ready[grant]=1. None eligible -> in_ready all 0.
- IDLE accept with in_last=1: stay IDLE, rr_ptr <= grant. Accept with in_last=0: -> LOCKED(grant), rr_ptr unchanged.
- LOCKED(p), almost_full=0: in_ready[p]=1 only (sub_afu_reset[p] ignored while locked; burst must complete). Other ports get no ready regardless of validity.
- LOCKED(p) accept with in_last=1: -> IDLE, rr_ptr <= p. Non-last accept or no valid: stay LOCKED(p).
- almost_full=1: in_ready all 0 in any state; state and rr_ptr hold.
- sub_afu_reset asserted for a port in IDLE: port never granted; deassertion makes it eligible next cycle.
- Reset: state IDLE, rr_ptr = NUM_SUB_AFUS-1 (first scan starts at port 0).

## Timing
- in_ready depends combinationally on in_valid, sub_afu_reset, almost_full, state, rr_ptr.
- Accepted beat appears on out_* exactly 1 cycle later with out_valid=1; cycles without accept give out_valid=0 (out_hdr/out_data don't-care, out_vmid/out_last 0).
- Throughput: one beat per cycle; back-to-back bursts from different ports with no idle cycle between last beat and next grant.
- Reset values: out_valid=0, out_last=0, out_vmid=0, out_hdr=0, out_data=0; in_ready all 0 during reset.
- almost_full seen in cycle t blocks accept in t; beat accepted in t-1 still emitted in t (relies on CCI-P almost-full headroom).

## Test plan
- Single port 3 valid single-beat, others idle -> out on three consecutive cycles, out_vmid=3, out_last=1 each, 1-cycle latency.
- Ports 0,2,5 continuously valid single-beat -> grant order 0,2,5,0,2,5...; no port served twice before others.
- Port 1 four-beat burst (last on beat 4), port 0 valid throughout -> beats 1..4 of port 1 contiguous on out, port 0 only after out_last; rr_ptr=1 so port 2+ before port 0 if eligible.
- almost_full high for 3 cycles during beat 2 of port 4's 4-beat burst -> in_ready all 0 for those cycles, no out_valid, burst resumes with port 4, no interleave.
- sub_afu_reset=0x4 with ports 2 and 3 valid -> only port 3 served; clear bit -> port 2 served next round; bit set mid-burst of port 2 -> burst completes.
- rr_ptr=7 (NUM_SUB_AFUS=8), ports 0 and 7 valid -> port 0 granted (wrap); reset asserted mid-burst -> out_valid 0 next cycle, state IDLE, next grant from port 0.
